// File: rtl/vx_tex_csr_slave.sv
// Texture CSR responder: per-warp CSR file with same-cycle reads, write commit,
// dirty tracking and a valid/ready per-warp snapshot port for the texture unit.

module vx_tex_csr_lane (
  input  logic        i_en,
  input  logic [31:0] i_val,
  output logic [31:0] o_data
);
  assign o_data = i_en ? i_val : 32'd0;
endmodule

module vx_tex_csr_slave #(
  parameter int          NUM_WARPS  = 4,
  parameter int          NUM_LANES  = 4,
  parameter int          PID_WIDTH  = 1,
  parameter logic [11:0] ADDR_BASE  = 12'h7C0,
  parameter int          NUM_CSRS   = 8,
  parameter int          UUID_WIDTH = 44,
  localparam int         WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int         IDX_W      = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_read_enable,
  input  logic [UUID_WIDTH-1:0]     i_read_uuid,
  input  logic [WID_W-1:0]          i_read_wid,
  input  logic [PID_WIDTH-1:0]      i_read_pid,
  input  logic [NUM_LANES-1:0]      i_read_tmask,
  input  logic [11:0]               i_read_addr,
  output logic [NUM_LANES*32-1:0]   o_read_data,
  input  logic                      i_write_enable,
  input  logic [UUID_WIDTH-1:0]     i_write_uuid,
  input  logic [WID_W-1:0]          i_write_wid,
  input  logic [PID_WIDTH-1:0]      i_write_pid,
  input  logic [NUM_LANES-1:0]      i_write_tmask,
  input  logic [11:0]               i_write_addr,
  input  logic [NUM_LANES*32-1:0]   i_write_data,
  input  logic                      i_cfg_req_valid,
  input  logic [WID_W-1:0]          i_cfg_req_wid,
  output logic                      o_cfg_req_ready,
  output logic                      o_cfg_rsp_valid,
  output logic [WID_W-1:0]          o_cfg_rsp_wid,
  output logic [NUM_CSRS*32-1:0]    o_cfg_rsp_data,
  input  logic                      i_cfg_rsp_ready,
  output logic [NUM_WARPS-1:0]      o_dirty
);
  // 13-bit end bound so ADDR_BASE+NUM_CSRS cannot wrap the 12-bit CSR space
  localparam logic [12:0] ADDR_END = {1'b0, ADDR_BASE} + 13'(NUM_CSRS);

  typedef enum logic {S_IDLE, S_RSP} state_t;

  logic [NUM_WARPS-1:0][NUM_CSRS-1:0][31:0] r_csrs;
  logic [NUM_WARPS-1:0]                     r_dirty;
  state_t                                   r_state;
  logic                                     r_req_ready;
  logic                                     r_rsp_valid;
  logic [WID_W-1:0]                         r_rsp_wid;
  logic [NUM_CSRS-1:0][31:0]                r_rsp_data;

  logic                       w_rd_hit, w_wr_hit, w_wr_go, w_accept;
  logic [IDX_W-1:0]           w_rd_idx, w_wr_idx;
  logic [31:0]                w_rd_val, w_wr_val;
  logic [NUM_LANES-1:0][31:0] w_rd_lane, w_wr_lane;
  logic [NUM_WARPS-1:0]       w_set, w_clr;
  logic                       w_unused;

  assign w_unused = ^{i_read_uuid, i_read_pid, i_write_uuid, i_write_pid};

  assign w_rd_hit = i_read_enable && (i_read_addr >= ADDR_BASE) && ({1'b0, i_read_addr} < ADDR_END);
  assign w_wr_hit = (i_write_addr >= ADDR_BASE) && ({1'b0, i_write_addr} < ADDR_END);
  assign w_wr_go  = i_write_enable && w_wr_hit && (|i_write_tmask);
  assign w_rd_idx = IDX_W'(i_read_addr - ADDR_BASE);
  assign w_wr_idx = IDX_W'(i_write_addr - ADDR_BASE);
  assign w_rd_val = r_csrs[i_read_wid][w_rd_idx];
  assign w_wr_lane = i_write_data;
  assign w_accept = i_cfg_req_valid && r_req_ready;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      vx_tex_csr_lane u_lane (
        .i_en   (w_rd_hit && i_read_tmask[g]),
        .i_val  (w_rd_val),
        .o_data (w_rd_lane[g])
      );
    end
  endgenerate

  assign o_read_data = w_rd_lane;

  // Scan high-to-low so the lowest active lane is the one left standing
  always_comb begin
    w_wr_val = 32'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (i_write_tmask[i]) w_wr_val = w_wr_lane[i];
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_wr_go)  w_set = NUM_WARPS'(1) << i_write_wid;
    if (w_accept) w_clr = NUM_WARPS'(1) << i_cfg_req_wid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csrs  <= '0;
      r_dirty <= '0;
    end else begin
      if (w_wr_go) r_csrs[i_write_wid][w_wr_idx] <= w_wr_val;
      r_dirty <= (r_dirty & ~w_clr) | w_set;
    end
  end

  // Snapshot samples r_csrs before this edge's write lands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_wid   <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_RSP;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_wid   <= i_cfg_req_wid;
            r_rsp_data  <= r_csrs[i_cfg_req_wid];
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_RSP: begin
          if (i_cfg_rsp_ready) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cfg_req_ready = r_req_ready;
  assign o_cfg_rsp_valid = r_rsp_valid;
  assign o_cfg_rsp_wid   = r_rsp_wid;
  assign o_cfg_rsp_data  = r_rsp_data;
  assign o_dirty         = r_dirty;

endmodule

// File: tb/tb_vx_tex_csr_slave.sv
// Directed bench for vx_tex_csr_slave: reset, read/write, range, collision,
// snapshot hold and write/accept set-wins.

module tb_vx_tex_csr_slave;
  localparam int NW = 4, NL = 4, NC = 8, UW = 44;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              rd_en = 0, wr_en = 0, req_v = 0, rsp_rdy = 0;
  logic [UW-1:0]     rd_uuid = '0, wr_uuid = '0;
  logic [1:0]        rd_wid = 0, wr_wid = 0, req_wid = 0, rsp_wid;
  logic [0:0]        rd_pid = 0, wr_pid = 0;
  logic [NL-1:0]     rd_tm = 0, wr_tm = 0;
  logic [11:0]       rd_addr = 0, wr_addr = 0;
  logic [NL*32-1:0]  rd_data, wr_data = '0;
  logic              req_rdy, rsp_v;
  logic [NC*32-1:0]  rsp_data, snap;
  logic [NW-1:0]     dirty;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  vx_tex_csr_slave dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_read_enable(rd_en), .i_read_uuid(rd_uuid), .i_read_wid(rd_wid), .i_read_pid(rd_pid),
    .i_read_tmask(rd_tm), .i_read_addr(rd_addr), .o_read_data(rd_data),
    .i_write_enable(wr_en), .i_write_uuid(wr_uuid), .i_write_wid(wr_wid), .i_write_pid(wr_pid),
    .i_write_tmask(wr_tm), .i_write_addr(wr_addr), .i_write_data(wr_data),
    .i_cfg_req_valid(req_v), .i_cfg_req_wid(req_wid), .o_cfg_req_ready(req_rdy),
    .o_cfg_rsp_valid(rsp_v), .o_cfg_rsp_wid(rsp_wid), .o_cfg_rsp_data(rsp_data),
    .i_cfg_rsp_ready(rsp_rdy), .o_dirty(dirty)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] w, input logic [11:0] a, input logic [3:0] tm, input logic [127:0] d);
    wr_en = 1; wr_wid = w; wr_addr = a; wr_tm = tm; wr_data = d;
  endtask

  task automatic rd(input logic [1:0] w, input logic [11:0] a, input logic [3:0] tm);
    rd_en = 1; rd_wid = w; rd_addr = a; rd_tm = tm; #1;
  endtask

  initial begin
    #2;
    chk("rst_dirty", 256'(dirty), 0);
    chk("rst_rsp_valid", 256'(rsp_v), 0);
    chk("rst_rsp_data", rsp_data, 0);
    #10 rst_n = 1;
    tick;
    chk("ready_after_rst", 256'(req_rdy), 1);

    // write wid0, then reset mid-cycle and confirm everything clears at once
    wr(0, 12'h7C0, 4'b0001, 128'h1234); tick; wr_en = 0;
    chk("pre_rst_dirty", 256'(dirty), 4'b0001);
    #2 rst_n = 0; #1;
    chk("midrst_dirty", 256'(dirty), 0);
    chk("midrst_ready", 256'(req_rdy), 0);
    rd(0, 12'h7C0, 4'b0001);
    chk("midrst_csr", 256'(rd_data), 0);
    rd_en = 0;
    #1 rst_n = 1;
    tick;
    chk("ready_after_rel", 256'(req_rdy), 1);

    // RW: lowest set lane (lane1 = AAAA) wins
    wr(2, 12'h7C3, 4'b0110, {32'h0, 32'hBBBB, 32'hAAAA, 32'h0}); tick; wr_en = 0;
    rd(2, 12'h7C3, 4'b1011);
    chk("rw_read", 256'(rd_data), {32'hAAAA, 32'h0, 32'hAAAA, 32'hAAAA});
    chk("rw_dirty", 256'(dirty), 4'b0100);
    rd_en = 0; #1;
    chk("rd_disabled", 256'(rd_data), 0);

    // Range edges and zero tmask
    wr(2, 12'h7C8, 4'b1111, {4{32'h77}}); tick;
    wr(2, 12'h7BF, 4'b1111, {4{32'h77}}); tick;
    wr(3, 12'h7C3, 4'b0000, {4{32'h99}}); tick; wr_en = 0;
    chk("range_dirty", 256'(dirty), 4'b0100);
    rd(2, 12'h7C8, 4'b1111); chk("rd_above", 256'(rd_data), 0);
    rd(2, 12'h7BF, 4'b1111); chk("rd_below", 256'(rd_data), 0);
    rd(2, 12'h7C7, 4'b1111); chk("rd_last_csr", 256'(rd_data), 0);
    rd(2, 12'h7C3, 4'b0001); chk("rd_unchanged", 256'(rd_data), 128'hAAAA);
    rd(3, 12'h7C3, 4'b1111); chk("zero_tmask", 256'(rd_data), 0);

    // Collision: no write-to-read bypass
    wr(0, 12'h7C5, 4'b0001, 128'h55);
    rd(0, 12'h7C5, 4'b0001);
    chk("coll_old", 256'(rd_data), 0);
    tick; wr_en = 0; #1;
    chk("coll_new", 256'(rd_data), 128'h55);
    rd_en = 0;
    chk("coll_dirty", 256'(dirty), 4'b0101);

    // Snapshot of wid2, held while wid2 is rewritten
    req_v = 1; req_wid = 2; #1;
    chk("snap_ready", 256'(req_rdy), 1);
    tick; req_v = 0;
    snap = '0; snap[96 +: 32] = 32'hAAAA;
    chk("snap_valid", 256'(rsp_v), 1);
    chk("snap_wid", 256'(rsp_wid), 2);
    chk("snap_data", rsp_data, snap);
    chk("snap_dirty", 256'(dirty), 4'b0001);
    wr(2, 12'h7C0, 4'b0001, 128'h1111); tick; wr_en = 0;
    tick; tick;
    chk("hold_data", rsp_data, snap);
    chk("hold_valid", 256'(rsp_v), 1);
    chk("hold_ready", 256'(req_rdy), 0);
    chk("hold_dirty", 256'(dirty), 4'b0101);
    rsp_rdy = 1; tick; rsp_rdy = 0;
    chk("drain_valid", 256'(rsp_v), 0);
    chk("drain_ready", 256'(req_rdy), 1);

    // Set-wins: write wid1 on the same edge its request is accepted
    wr(1, 12'h7C2, 4'b0001, 128'hC0DE); tick;
    wr(1, 12'h7C2, 4'b1000, {32'hBEEF, 96'h0});
    req_v = 1; req_wid = 1;
    tick; wr_en = 0; req_v = 0;
    snap = '0; snap[64 +: 32] = 32'hC0DE;
    chk("setwin_snap", rsp_data, snap);
    chk("setwin_dirty", 256'(dirty), 4'b0111);
    rd(1, 12'h7C2, 4'b0001); chk("setwin_csr", 256'(rd_data), 128'hBEEF);
    rd_en = 0;
    rsp_rdy = 1; tick; rsp_rdy = 0;
    req_v = 1; req_wid = 1; tick; req_v = 0;
    snap[64 +: 32] = 32'hBEEF;
    chk("resnap_data", rsp_data, snap);
    chk("resnap_dirty", 256'(dirty), 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
